// File: rtl/seven_seg_pkg.sv
// Shared glyph table, blank constant and capture FSM state type for the
// seven-segment capture decoder.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;

    // Active-high glyphs, bit0=a .. bit6=g, indexed by hex value.
    localparam logic [SEG_W-1:0] SEG_GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } cap_state_t;

    function automatic logic [SEG_W-1:0] seg_active_high(input logic [SEG_W-1:0] seg_n);
        return ~seg_n;
    endfunction

endpackage

// File: rtl/seven_segment_to_hex.sv
// Combinational reverse glyph lookup: active-high 7-bit pattern to {hit, hex}.
module seven_segment_to_hex
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic             o_hit,
    output logic [3:0]       o_hex
);

    // Glyphs are unique, so at most one entry can match.
    always_comb begin
        o_hit = 1'b0;
        o_hex = 4'h0;
        for (int i = 0; i < 16; i++) begin
            o_hit = o_hit | (i_seg == SEG_GLYPH[i]);
            o_hex = (i_seg == SEG_GLYPH[i]) ? 4'(i) : o_hex;
        end
    end

endmodule

// File: rtl/seven_segment_capture_decoder.sv
// Recovers per-digit hex values from a multiplexed active-low seven-segment bus.
// Optional macro BLANK_DETECT_EN: an all-off pattern clears the digit silently.
module seven_segment_capture_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_idx,
    output logic [3:0]              out_hex,
    output logic                    out_err,
    output logic                    overflow
);

    logic [6:0]              r_seg_smp;
    logic [NUM_DIGITS-1:0]   r_sel_smp;
    cap_state_t              r_state;
    cap_state_t              w_state_nxt;
    logic [6:0]              r_lat_seg;
    logic [NUM_DIGITS-1:0]   r_lat_sel;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_nxt;
    logic                    w_load;
    logic                    w_capture;
    logic                    w_onehot;
    logic                    w_same;
    logic [6:0]              w_seg_on;
    logic                    w_hit;
    logic [3:0]              w_hex;
    logic [2:0]              w_idx;
    logic                    w_post;
    logic [4*NUM_DIGITS-1:0] r_hex_digits;
    logic [NUM_DIGITS-1:0]   r_digit_valid;
    logic                    r_out_valid;
    logic [2:0]              r_out_idx;
    logic [3:0]              r_out_hex;
    logic                    r_out_err;
    logic                    r_overflow;

    // Input sample stage; everything downstream looks only at these copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_smp <= 7'h00;
            r_sel_smp <= '0;
        end else begin
            r_seg_smp <= seg_n;
            r_sel_smp <= dig_sel;
        end
    end

    assign w_onehot = $onehot(r_sel_smp);
    assign w_same   = (r_seg_smp == r_lat_seg) && (r_sel_smp == r_lat_sel);

    // Stability FSM state, latched pattern and run counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_lat_seg <= 7'h00;
            r_lat_sel <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_lat_seg <= r_seg_smp;
                r_lat_sel <= r_sel_smp;
            end
        end
    end

    // Next-state: a capture fires on the sample that completes STABLE_CYCLES matches.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_onehot) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = SETTLE;
                end else begin
                    w_cnt_nxt   = 8'd0;
                end
            end
            SETTLE: begin
                if (!w_onehot) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = IDLE;
                end else if (!w_same) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = 8'd1;
                end else if (r_cnt == 8'(STABLE_CYCLES - 1)) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 8'(STABLE_CYCLES);
                    w_state_nxt = CAPTURED;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            CAPTURED: begin
                if (w_same) begin
                    w_state_nxt = CAPTURED;
                end else if (w_onehot) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = SETTLE;
                end else begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_seg_on = seg_active_high(r_lat_seg);

    seven_segment_to_hex u_seg_to_hex (
        .i_seg (w_seg_on),
        .o_hit (w_hit),
        .o_hex (w_hex)
    );

    // One-hot latched select to digit index.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_idx = r_lat_sel[i] ? 3'(i) : w_idx;
        end
    end

`ifdef BLANK_DETECT_EN
    logic w_blank;
    assign w_blank = (w_seg_on == SEG_BLANK);
    assign w_post  = w_capture & ~w_blank;
`else
    assign w_post  = w_capture;
`endif

    // Digit table update and single-entry event buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex_digits  <= '0;
            r_digit_valid <= '0;
            r_out_valid   <= 1'b0;
            r_out_idx     <= 3'd0;
            r_out_hex     <= 4'h0;
            r_out_err     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (r_lat_sel[i]) begin
                        if (w_hit) begin
                            r_hex_digits[4*i +: 4] <= w_hex;
                            r_digit_valid[i]       <= 1'b1;
                        end
`ifdef BLANK_DETECT_EN
                        else if (w_blank) begin
                            r_digit_valid[i] <= 1'b0;
                        end
`endif
                    end
                end
            end
            // A same-cycle accept frees the slot for the new event.
            if (w_post) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_idx   <= w_idx;
                    r_out_hex   <= w_hit ? w_hex : 4'h0;
                    r_out_err   <= ~w_hit;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign hex_digits  = r_hex_digits;
    assign digit_valid = r_digit_valid;
    assign out_valid   = r_out_valid;
    assign out_idx     = r_out_idx;
    assign out_hex     = r_out_hex;
    assign out_err     = r_out_err;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_seven_segment_capture_decoder.sv
// Randomised and directed bench for seven_segment_capture_decoder against a
// sample-history reference model.
module tb_seven_segment_capture_decoder;

    localparam int ND = 4;
    localparam int SC = 8;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel;
    logic        out_ready;
    logic [15:0] hex_digits;
    logic [3:0]  digit_valid;
    logic        out_valid;
    logic [2:0]  out_idx;
    logic [3:0]  out_hex;
    logic        out_err;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_segment_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .hex_digits  (hex_digits),
        .digit_valid (digit_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_hex     (out_hex),
        .out_err     (out_err),
        .overflow    (overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: history of registered samples (index 0 = newest seen by the decoder).
    logic [10:0] hist [0:SC];
    logic [10:0] smp;
    logic [15:0] m_hex;
    logic [3:0]  m_dv;
    logic        m_valid;
    logic [2:0]  m_idx;
    logic [3:0]  m_hexo;
    logic        m_err;
    logic        m_ov;
    bit          model_ok = 1'b0;
    logic [7:0]  acc_q [$];

    initial begin : model
        logic acc;
        logic cap;
        logic post;
        logic hit;
        logic [6:0] on;
        logic [3:0] val;
        int idx;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i <= SC; i++) hist[i] = 11'd0;
                smp = 11'd0; m_hex = 16'h0; m_dv = 4'h0; m_valid = 1'b0;
                m_idx = 3'd0; m_hexo = 4'h0; m_err = 1'b0; m_ov = 1'b0;
                model_ok = 1'b1;
            end else begin
                acc = m_valid && out_ready;
                if (acc) acc_q.push_back({m_idx, m_hexo, m_err});
                for (int i = SC; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = smp;
                // Capture exactly when the identical one-hot run length reaches SC.
                cap = $onehot(hist[0][3:0]);
                for (int i = 1; i < SC; i++) if (hist[i] != hist[0]) cap = 1'b0;
                if (hist[SC] == hist[0]) cap = 1'b0;
                post = 1'b0;
                if (cap) begin
                    on = ~hist[0][10:4];
                    hit = 1'b0; val = 4'h0; idx = 0;
                    for (int k = 0; k < 16; k++) if (GLYPH[k] == on) begin hit = 1'b1; val = 4'(k); end
                    for (int i = 0; i < ND; i++) if (hist[0][i]) idx = i;
                    if (hit) begin
                        m_hex[4*idx +: 4] = val;
                        m_dv[idx] = 1'b1;
                        post = 1'b1;
                    end else begin
`ifdef BLANK_DETECT_EN
                        if (on == 7'h00) m_dv[idx] = 1'b0;
                        else post = 1'b1;
`else
                        post = 1'b1;
`endif
                    end
                    if (post) begin
                        if (!m_valid || acc) begin
                            m_valid = 1'b1; m_idx = 3'(idx); m_hexo = val; m_err = ~hit;
                        end else begin
                            m_ov = 1'b1;
                        end
                    end else if (acc) begin
                        m_valid = 1'b0;
                    end
                end else if (acc) begin
                    m_valid = 1'b0;
                end
                smp = {seg_n, dig_sel};
            end
        end
    end

    // Per-cycle comparison of DUT against the model, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("hex_digits", 32'(hex_digits), 32'(m_hex));
                chk("digit_valid", 32'(digit_valid), 32'(m_dv));
                chk("out_valid", 32'(out_valid), 32'(m_valid));
                chk("overflow", 32'(overflow), 32'(m_ov));
                if (m_valid && out_valid) begin
                    chk("out_idx", 32'(out_idx), 32'(m_idx));
                    chk("out_hex", 32'(out_hex), 32'(m_hexo));
                    chk("out_err", 32'(out_err), 32'(m_err));
                end
            end
        end
    end

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seg_n = s; dig_sel = d; out_ready = r;
        end
    endtask

    logic [6:0] scan_seg [4] = '{7'h79, 7'h08, 7'h24, 7'h00};
    logic [3:0] scan_hex [4] = '{4'h1, 4'hA, 4'h2, 4'h8};

    initial begin : stim
        int cyc;
        int n;
        logic [6:0] s;
        logic [3:0] d;
        logic [3:0] k;
        reset = 1'b1; seg_n = 7'h7F; dig_sel = 4'h0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_hex", 32'(hex_digits), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_dv", 32'(digit_valid), 32'h0);

        // Single stable digit.
        acc_q.delete();
        drive(7'h40, 4'b0001, 1'b1, 20);
        drive(7'h7F, 4'b0000, 1'b1, 3);
        chk("t1_events", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) chk("t1_event", 32'(acc_q[0]), 32'({3'd0, 4'h0, 1'b0}));
        chk("t1_hex", 32'(hex_digits[3:0]), 32'h0);
        chk("t1_dv", 32'(digit_valid), 32'h1);

        // Scan all four digits.
        acc_q.delete();
        for (int i = 0; i < 4; i++) drive(scan_seg[i], 4'(1 << i), 1'b1, 10);
        drive(7'h7F, 4'b0000, 1'b1, 3);
        chk("scan_hex", 32'(hex_digits), 32'h82A1);
        chk("scan_dv", 32'(digit_valid), 32'hF);
        chk("scan_events", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++)
            chk("scan_event", 32'(acc_q[i]), 32'({3'(i), scan_hex[i], 1'b0}));

        // Toggling faster than the stability window.
        acc_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(7'h40, 4'b0001, 1'b1, 5);
            drive(7'h79, 4'b0001, 1'b1, 5);
        end
        drive(7'h7F, 4'b0000, 1'b1, 3);
        chk("toggle_events", 32'(acc_q.size()), 32'd0);
        chk("toggle_hex", 32'(hex_digits), 32'h82A1);

        // Multi-hot select.
        drive(7'h40, 4'b0011, 1'b1, 30);
        drive(7'h7F, 4'b0000, 1'b1, 3);
        chk("multihot_events", 32'(acc_q.size()), 32'd0);

        // Back-pressure: second capture dropped.
        drive(7'h40, 4'b0100, 1'b0, 10);
        drive(7'h79, 4'b1000, 1'b0, 10);
        drive(7'h7F, 4'b0000, 1'b0, 2);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_pending", 32'(out_valid), 32'h1);
        chk("ovf_idx", 32'(out_idx), 32'd2);
        chk("ovf_hex", 32'(hex_digits), 32'h10A1);
        drive(7'h7F, 4'b0000, 1'b1, 3);
        chk("ovf_events", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) chk("ovf_event", 32'(acc_q[0]), 32'({3'd2, 4'h0, 1'b0}));
        chk("ovf_drained", 32'(out_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Blank pattern on digit 1.
        acc_q.delete();
        drive(7'h7F, 4'b0010, 1'b1, 12);
        drive(7'h7F, 4'b0000, 1'b1, 3);
`ifdef BLANK_DETECT_EN
        chk("blank_events", 32'(acc_q.size()), 32'd0);
        chk("blank_dv", 32'(digit_valid), 32'hD);
`else
        chk("blank_events", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) chk("blank_event", 32'(acc_q[0]), 32'({3'd1, 4'h0, 1'b1}));
        chk("blank_dv", 32'(digit_valid), 32'hF);
`endif
        chk("blank_hex", 32'(hex_digits), 32'h10A1);

        // Reset with an event pending and another digit mid-settle.
        drive(7'h24, 4'b0001, 1'b0, 12);
        drive(7'h79, 4'b0010, 1'b0, 5);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        chk("rst2_hex", 32'(hex_digits), 32'h0);
        chk("rst2_dv", 32'(digit_valid), 32'h0);
        chk("rst2_valid", 32'(out_valid), 32'h0);
        chk("rst2_ovf", 32'(overflow), 32'h0);

        // Randomised hold lengths, patterns, selects and back-pressure.
        cyc = 0;
        while (cyc < 1500) begin
            n = $urandom_range(1, 12);
            k = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 3) != 0) ? ~GLYPH[k] : 7'($urandom);
            d = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            drive(s, d, 1'($urandom), n);
            cyc += n;
        end
        drive(7'h7F, 4'b0000, 1'b1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
